// File: rtl/demux1to4_stream_if.sv
// demux1to4_stream_if
//   Handshake and data bundle for the 1-to-4 stream demultiplexer.
//   Input side : in_valid/in_ready/in_data/in_sel (+ in_bcast when
//                DEMUX1TO4_BROADCAST_EN is defined).
//   Output side: out_valid[3:0]/out_ready[3:0], out_data0..3 (head words),
//                out_count (packed per-channel occupancy, W bits each).
//   master : the surrounding producer/consumers.
//   slave  : the demux itself.
interface demux1to4_stream_if #(
    parameter int N     = 32,
    parameter int DEPTH = 2
);
    localparam int W = $clog2(DEPTH) + 1;

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;
    logic [1:0]     in_sel;
`ifdef DEMUX1TO4_BROADCAST_EN
    logic           in_bcast;
`endif
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [N-1:0]   out_data0;
    logic [N-1:0]   out_data1;
    logic [N-1:0]   out_data2;
    logic [N-1:0]   out_data3;
    logic [4*W-1:0] out_count;

    modport master (
`ifdef DEMUX1TO4_BROADCAST_EN
        output in_bcast,
`endif
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
        input  out_count
    );

    modport slave (
`ifdef DEMUX1TO4_BROADCAST_EN
        input  in_bcast,
`endif
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
        output out_count
    );
endinterface

// File: rtl/demux1to4_stream.sv
// demux1to4_stream
//   Routes one N-bit word per cycle from a valid/ready input into one of
//   four DEPTH-entry FIFOs selected by in_sel; each FIFO drains on its own
//   valid/ready output, so a stalled consumer only blocks its own lane.
//   Ports:
//     clk - single clock, rising edge
//     rst - synchronous, active-high reset; clears pointers, counts, storage
//     bus - demux1to4_stream_if.slave (input handshake, four output lanes,
//           packed occupancy)
//   Optional: DEMUX1TO4_BROADCAST_EN adds bus.in_bcast, which pushes the
//   word into all four FIFOs at once (accepted only when none is full).
module demux1to4_stream #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    demux1to4_stream_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = AW + 1;
    localparam logic [W-1:0]  CNT_FULL = W'(DEPTH);
    localparam logic [W-1:0]  CNT_ONE  = W'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [N-1:0]   mem    [4][DEPTH];
    logic [AW-1:0]  rd_ptr [4];
    logic [AW-1:0]  wr_ptr [4];
    logic [W-1:0]   count  [4];

    logic [3:0]     full;
    logic [3:0]     empty;
    logic [3:0]     push;
    logic [3:0]     pop;
    logic           ready;
    logic [N-1:0]   head   [4];
    logic [4*W-1:0] count_flat;

    always_comb begin
        full       = '0;
        empty      = '0;
        count_flat = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]              = (count[i] == CNT_FULL);
            empty[i]             = (count[i] == '0);
            head[i]              = mem[i][rd_ptr[i]];
            count_flat[i*W +: W] = count[i];
        end
    end

    // in_ready looks only at in_sel (or in_bcast) and occupancy, never at
    // in_valid or out_ready: a full lane stays closed even if it pops now.
    always_comb begin
        ready = 1'b0;
        push  = '0;
`ifdef DEMUX1TO4_BROADCAST_EN
        if (bus.in_bcast) begin
            ready = !rst && !(|full);
            push  = {4{bus.in_valid && ready}};
        end else begin
            ready = !rst && !full[bus.in_sel];
            push[bus.in_sel] = bus.in_valid && ready;
        end
`else
        ready = !rst && !full[bus.in_sel];
        push[bus.in_sel] = bus.in_valid && ready;
`endif
    end

    assign pop = ~empty & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= bus.in_data;
                    wr_ptr[i]         <= wr_ptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = ~empty;
    assign bus.out_data0 = head[0];
    assign bus.out_data1 = head[1];
    assign bus.out_data2 = head[2];
    assign bus.out_data3 = head[3];
    assign bus.out_count = count_flat;
endmodule

// File: tb/tb_demux1to4_stream.sv
module tb_demux1to4_stream;
    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    demux1to4_stream_if #(.N(N), .DEPTH(DEPTH)) bus ();

    demux1to4_stream #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1234_5678;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;
`ifdef DEMUX1TO4_BROADCAST_EN
        bus.in_bcast  = 1'b0;
`endif
        cycle();
        cycle();
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.out_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_state valid=%b count=%h exp 0000/00", bus.out_valid, bus.out_count);
        end
        total++;
        if (bus.out_data0 !== 0 || bus.out_data1 !== 0 || bus.out_data2 !== 0 || bus.out_data3 !== 0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3);
        end
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL idle_in_ready sel=%0d got=%b exp=1", s, bus.in_ready);
            end
        end
        cycle();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL idle_no_push got=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_single_push();
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hA5A5_0001;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0100 || bus.out_data2 !== 32'hA5A5_0001 || bus.out_count !== 8'h10) begin
            bad++;
            $display("FAIL single_push valid=%b data2=%h count=%h exp 0100/a5a50001/10", bus.out_valid, bus.out_data2, bus.out_count);
        end
        // Stable while not ready
        cycle();
        total++;
        if (bus.out_data2 !== 32'hA5A5_0001 || bus.out_count !== 8'h10) begin
            bad++;
            $display("FAIL hold_stable data2=%h count=%h exp a5a50001/10", bus.out_data2, bus.out_count);
        end
        // out_ready on empty lanes is ignored
        bus.out_ready = 4'b1111;
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.out_count !== 8'h00) begin
            bad++;
            $display("FAIL drain_no_underflow valid=%b count=%h exp 0000/00", bus.out_valid, bus.out_count);
        end
    endtask

    task automatic test_full();
        bus.in_sel   = 2'd1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h11;
        cycle();
        bus.in_data  = 32'h22;
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_count !== 8'h08 || bus.out_data1 !== 32'h11) begin
            bad++;
            $display("FAIL full_fill count=%h data1=%h exp 08/11", bus.out_count, bus.out_data1);
        end
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_sel1_ready got=%b exp=0", bus.in_ready);
        end
        bus.in_sel = 2'd0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_sel0_ready got=%b exp=1", bus.in_ready);
        end
        // Pop on the full lane does not open in_ready in the same cycle
        bus.in_sel    = 2'd1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h33;
        bus.out_ready = 4'b0010;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_ready got=%b exp=0", bus.in_ready);
        end
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_count !== 8'h04 || bus.out_data1 !== 32'h22 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_after_pop count=%h data1=%h ready=%b exp 04/22/1", bus.out_count, bus.out_data1, bus.in_ready);
        end
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_count !== 8'h08 || bus.out_data1 !== 32'h22) begin
            bad++;
            $display("FAIL full_repush count=%h data1=%h exp 08/22", bus.out_count, bus.out_data1);
        end
        bus.out_ready = 4'b0010;
        cycle();
        total++;
        if (bus.out_data1 !== 32'h33 || bus.out_count !== 8'h04) begin
            bad++;
            $display("FAIL full_order data1=%h count=%h exp 33/04", bus.out_data1, bus.out_count);
        end
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL full_drained got=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_interleave();
        logic [N-1:0] got;
        bus.out_ready = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            bus.in_sel   = 2'((k - 1) % 4);
            bus.in_data  = 32'(k);
            bus.in_valid = 1'b1;
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL inter_ready k=%0d got=%b exp=1", k, bus.in_ready);
            end
            cycle();
            case ((k - 1) % 4)
                0:       got = bus.out_data0;
                1:       got = bus.out_data1;
                2:       got = bus.out_data2;
                default: got = bus.out_data3;
            endcase
            total++;
            if (bus.out_valid !== 4'(1 << ((k - 1) % 4)) || got !== 32'(k)
                || bus.out_count !== 8'(1 << (2 * ((k - 1) % 4)))) begin
                bad++;
                $display("FAIL inter_word k=%0d valid=%b data=%h count=%h", k, bus.out_valid, got, bus.out_count);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.out_count !== 8'h00) begin
            bad++;
            $display("FAIL inter_drained valid=%b count=%h exp 0000/00", bus.out_valid, bus.out_count);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_sel   = 2'd3;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 32'h300 + 32'(k);
            cycle();
        end
        total++;
        if (bus.out_count !== 8'h80 || bus.out_data3 !== 32'h300) begin
            bad++;
            $display("FAIL mid_fill count=%h data3=%h exp 80/300", bus.out_count, bus.out_data3);
        end
        rst         = 1'b1;
        bus.in_sel  = 2'd0;
        bus.in_data = 32'hBAD0_0000;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_ready got=%b exp=0", bus.in_ready);
        end
        cycle();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.out_count !== 8'h00 || bus.out_data3 !== 0 || bus.out_data0 !== 0) begin
            bad++;
            $display("FAIL mid_rst_state valid=%b count=%h d3=%h d0=%h", bus.out_valid, bus.out_count, bus.out_data3, bus.out_data0);
        end
        cycle();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rst_inflight got=%b exp=0000", bus.out_valid);
        end
    endtask

`ifdef DEMUX1TO4_BROADCAST_EN
    task automatic test_broadcast();
        bus.in_bcast = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        total++;
        if (bus.out_valid !== 4'b1111 || bus.out_count !== 8'h55
            || bus.out_data0 !== 32'hDEAD_BEEF || bus.out_data1 !== 32'hDEAD_BEEF
            || bus.out_data2 !== 32'hDEAD_BEEF || bus.out_data3 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL bcast_push valid=%b count=%h d0=%h d3=%h", bus.out_valid, bus.out_count, bus.out_data0, bus.out_data3);
        end
        bus.out_ready = 4'b1111;
        cycle();
        bus.out_ready = 4'b0000;
        bus.in_sel    = 2'd0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        cycle();
        bus.in_data   = 32'hB;
        cycle();
        bus.in_bcast  = 1'b1;
        bus.in_data   = 32'h00C0_FFEE;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bcast_blocked got=%b exp=0", bus.in_ready);
        end
        cycle();
        total++;
        if (bus.out_count !== 8'h02) begin
            bad++;
            $display("FAIL bcast_held count=%h exp=02", bus.out_count);
        end
        bus.out_ready = 4'b0001;
        cycle();
        bus.out_ready = 4'b0000;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_count !== 8'h01) begin
            bad++;
            $display("FAIL bcast_open ready=%b count=%h exp 1/01", bus.in_ready, bus.out_count);
        end
        cycle();
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        total++;
        if (bus.out_count !== 8'h56 || bus.out_data0 !== 32'hB || bus.out_data1 !== 32'h00C0_FFEE) begin
            bad++;
            $display("FAIL bcast_after count=%h d0=%h d1=%h exp 56/b/c0ffee", bus.out_count, bus.out_data0, bus.out_data1);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_push();
        test_full();
        test_interleave();
        test_reset_mid();
`ifdef DEMUX1TO4_BROADCAST_EN
        test_broadcast();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
- 1-to-4 stream demultiplexer: the inverse of the 4:1 datapath mux.
- Accepts one N-bit word per cycle on a valid/ready input, tagged with a 2-bit destination select.
- Routes each word into one of four per-channel FIFOs, each drained independently on its own valid/ready output.
- Sits between the execute/writeback stage and the four consumer lanes (e.g. vector lane writeback or memory-port queues) so one stalled consumer does not block the others until its own FIFO fills.

Parameters:
- N, 32, data width of every input/output word.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word on in_sel this cycle.
- in_data  input  N  input word.
- in_sel  input  2  destination channel 0..3.
- out_valid  output  4  bit i: channel i head word valid.
- out_ready  input  4  bit i: consumer i takes head word.
- out_data0..out_data3  output  N each  head word of channel 0..3.
- out_count  output  4*(log2(DEPTH)+1)  packed occupancy; channel i in bits [i*W +: W], W=log2(DEPTH)+1.

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst); no asynchronous paths.
- Reset (rst=1 at a clock edge):
  - all FIFOs empty; pointers 0.
  - out_valid=4'b0000, out_count=0, out_data0..3=0 (storage cleared).
  - in_ready is 0 while rst is high.
  - Reset mid-transfer discards all queued words; no handshake completes in a reset cycle.
- Input handshake:
  - in_ready = !rst && !full[in_sel]; combinational from in_sel and channel state only, never from in_valid.
  - Push occurs when in_valid && in_ready.
  - The word is written into FIFO[in_sel] at the edge.
- Output handshake, per channel i:
  - out_valid[i] = !empty[i].
  - out_data_i = FIFO[i] head word.
  - Pop occurs when out_valid[i] && out_ready[i].
  - out_data_i must remain stable while out_valid[i]=1 and out_ready[i]=0.
- Latency:
  - A word pushed at edge t appears on out_data at t+1 with out_valid set.
  - There is no combinational in-to-out bypass, even when the FIFO is empty.
- Full boundary:
  - A full channel deasserts in_ready when selected, even if the same channel pops in that cycle. No push/pop bypass when full; throughput on a full channel drops to 1 word per 2 cycles. This is intentional to keep in_ready free of out_ready paths.
- Empty boundary:
  - out_ready on an empty channel is ignored; count never underflows.
- Simultaneous events:
  - Push and pop on the same non-full, non-empty channel: count unchanged, both take effect.
  - Pops on multiple channels in one cycle are independent.
  - A push to channel A coincident with pops on B..D is legal.
- Pointers:
  - log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
  - count is (log2(DEPTH)+1) bits, range 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
- Ordering:
  - Strict FIFO per channel.
  - No ordering guarantee across channels.
- Data is passed unmodified; no arithmetic on the payload.

Optional Feature:
- Macro: DEMUX1TO4_BROADCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored and in_ready = !rst && no channel full.
  - On handshake, the word is pushed into all four FIFOs at the same edge; all four counts increment (minus any concurrent pop).
- Not defined:
  - Port absent.
  - Behaviour is exactly the unicast behaviour above.

Test Plan:
- Reset then idle -> out_valid=0000, out_count=0, out_data0..3=0, in_ready=1 for every in_sel.
- Push 0xA5A5_0001 sel=2 at edge t, all out_ready=0 -> at t+1: out_valid=0100, out_data2=0xA5A5_0001, channel 2 count=1, others 0.
- Fill channel 1 with 0x11, 0x22 (DEPTH=2), out_ready=0:
  - sel=1 -> in_ready=0 while sel=0 -> in_ready=1.
  - Raise out_ready[1] with in_valid on sel=1 -> pop 0x11, no push that cycle; next cycle in_ready=1 and push accepted.
- Interleave pushes 0x1..0x8 with sel cycling 0,1,2,3, all out_ready=1 -> each channel emits its two words in order (ch0: 0x1 then 0x5, etc.), never more than 1 queued.
- Push three words to channel 3, assert rst for one cycle with in_valid=1 -> all empty, out_valid=0000, the in-flight word is not stored.
- With DEMUX1TO4_BROADCAST_EN: push 0xDEAD_BEEF, in_bcast=1 -> next cycle out_valid=1111, all out_data=0xDEAD_BEEF. With channel 0 full, broadcast is held off (in_ready=0) until channel 0 pops.
